// File: rtl/oqpsk_pkg.sv
// Shared constants, FSM state codes and decision helper for the OQPSK modem blocks.
package oqpsk_pkg;
   localparam int OQPSK_W   = 13;
   localparam int OQPSK_SPB = 16;
   localparam int OQPSK_AW  = OQPSK_W + $clog2(2 * OQPSK_SPB);
   // Pulse-shaping table address width used by the modulator (one symbol per table).
   localparam int OQPSK_TBL_AW = $clog2(2 * OQPSK_SPB);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // Hard decision: a non-negative sum (including zero) decides 1.
   function automatic logic sign_to_bit(input logic sum_msb);
      return ~sum_msb;
   endfunction
endpackage

// File: rtl/oqpsk_iad_branch.sv
// One integrate-and-dump branch: load/add accumulator, sign decision on acc + current sample.
// Erasure compare present only with OQPSK_DEMOD_ERASE_EN.
module oqpsk_iad_branch
   import oqpsk_pkg::*;
#(
   parameter int W      = OQPSK_W,
   parameter int AW     = OQPSK_AW,
   parameter int THRESH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] x,
   output logic         dec
`ifdef OQPSK_DEMOD_ERASE_EN
   ,
   output logic         erase
`endif
);
   logic [AW-1:0] acc_q, acc_d, x_ext, sum;

   always_comb begin
      x_ext = {{(AW-W){x[W-1]}}, x};
      sum   = acc_q + x_ext;
      acc_d = acc_q;
      if (en) acc_d = load ? x_ext : sum;
      dec   = sign_to_bit(sum[AW-1]);
   end

`ifdef OQPSK_DEMOD_ERASE_EN
   localparam logic signed [AW-1:0] THR = AW'(THRESH);
   always_comb erase = ($signed(sum) < THR) && ($signed(sum) > -THR);
`endif

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end
endmodule

// File: rtl/oqpsk_demod_iad.sv
// OQPSK integrate-and-dump demodulator: phase counter, IDLE/FILL/RUN FSM, I/Q branches,
// alternating I,Q bit output. Optional erasure flag under OQPSK_DEMOD_ERASE_EN.
module oqpsk_demod_iad
   import oqpsk_pkg::*;
#(
   parameter int W      = OQPSK_W,
   parameter int SPB    = OQPSK_SPB,
   parameter int THRESH = 64
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         SYNC,
   input  logic [W-1:0] I,
   input  logic [W-1:0] Q,
   output logic         BitOut,
   output logic         BitValid,
   output logic         Erase,
   output logic         Locked
);
   localparam int AW = W + $clog2(2 * SPB);
   localparam int PW = $clog2(2 * SPB);
   localparam logic [PW-1:0] PH_LAST = PW'(2 * SPB - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(SPB);
   localparam logic [PW-1:0] PH_QDEC = PW'(SPB - 1);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] ph_q, ph_d;
   logic          bit_q, bit_d, valid_q, valid_d, locked_q, locked_d;
   logic          restart, adv, i_en, i_load, i_dump, q_load, q_dump, i_dec, q_dec;

   always_comb begin
      // A SYNC sample always restarts, discarding partial windows without a decision.
      restart  = EN & SYNC;
      adv      = EN & ~SYNC & (state_q != ST_IDLE);
      i_en     = restart | adv;
      i_load   = restart | (ph_q == '0);
      i_dump   = adv & (ph_q == PH_LAST);
      q_load   = (ph_q == PH_HALF);
      q_dump   = adv & (state_q == ST_RUN) & (ph_q == PH_QDEC);
      ph_d     = ph_q;
      state_d  = state_q;
      locked_d = locked_q;
      if (restart) begin
         ph_d     = PW'(1);
         state_d  = ST_FILL;
         locked_d = 1'b0;
      end else if (adv) begin
         ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
         if (i_dump) state_d = ST_RUN;
         if (q_dump) locked_d = 1'b1;
      end
      valid_d = i_dump | q_dump;
      bit_d   = i_dump ? i_dec : (q_dump ? q_dec : bit_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         ph_q     <= '0;
         bit_q    <= 1'b0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ph_q     <= ph_d;
         bit_q    <= bit_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
      end
   end

`ifdef OQPSK_DEMOD_ERASE_EN
   logic i_er, q_er, erase_q, erase_d;
   always_comb erase_d = i_dump ? i_er : (q_dump ? q_er : erase_q);
   always_ff @(posedge CLK) begin
      if (RST) erase_q <= 1'b0;
      else     erase_q <= erase_d;
   end
   assign Erase = erase_q & valid_q;
`else
   assign Erase = 1'b0;
`endif

   oqpsk_iad_branch #(.W(W), .AW(AW), .THRESH(THRESH)) u_br_i (
      .clk(CLK), .rst(RST), .en(i_en), .load(i_load), .x(I), .dec(i_dec)
`ifdef OQPSK_DEMOD_ERASE_EN
      , .erase(i_er)
`endif
   );

   oqpsk_iad_branch #(.W(W), .AW(AW), .THRESH(THRESH)) u_br_q (
      .clk(CLK), .rst(RST), .en(adv), .load(q_load), .x(Q), .dec(q_dec)
`ifdef OQPSK_DEMOD_ERASE_EN
      , .erase(q_er)
`endif
   );

   assign BitOut   = bit_q;
   assign BitValid = valid_q;
   assign Locked   = locked_q;
endmodule
